// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register with valid/ready handshake, flush and
// stall counter. SKID selects a plain register or a two-entry skid buffer.
module pipe_stage_elastic #(
   parameter int unsigned      WIDTH     = 64,
   parameter int unsigned      SKID      = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int unsigned      CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= '0;
      end else if (out_valid && !out_ready && (stall_count != '1)) begin
         stall_count <= stall_count + CNT_ONE;
      end
   end

   if (SKID == 0) begin : g_single
      logic             valid_q;
      logic [WIDTH-1:0] data_q;

      assign in_ready  = !flush && (out_ready || !valid_q);
      assign out_valid = valid_q;
      assign out_data  = data_q;
      assign occupancy = {1'b0, valid_q};

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
         end else if (flush) begin
            valid_q <= 1'b0;
         end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
         end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end else begin : g_skid
      typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

      state_t           state_q, state_d;
      logic [WIDTH-1:0] main_q, skid_q;
      logic             in_xfer, out_xfer;

      // in_ready depends only on registered state and flush, never on out_ready
      assign in_ready = (state_q != FULL) && !flush;
      assign in_xfer  = in_valid && in_ready;
      assign out_xfer = out_valid && out_ready;
      assign out_data = main_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) state_q <= EMPTY;
         else     state_q <= state_d;
      end

      always_comb begin
         state_d = state_q;
         if (flush) begin
            state_d = EMPTY;
         end else begin
            case (state_q)
               EMPTY: if (in_xfer) state_d = ONE;
               ONE: begin
                  if (in_xfer && !out_xfer)      state_d = FULL;
                  else if (!in_xfer && out_xfer) state_d = EMPTY;
               end
               FULL:    if (out_xfer) state_d = ONE;
               default: state_d = EMPTY;
            endcase
         end
      end

      always_comb begin
         out_valid = 1'b0;
         occupancy = 2'd0;
         case (state_q)
            ONE: begin
               out_valid = 1'b1;
               occupancy = 2'd1;
            end
            FULL: begin
               out_valid = 1'b1;
               occupancy = 2'd2;
            end
            default: begin
               out_valid = 1'b0;
               occupancy = 2'd0;
            end
         endcase
      end

      // Flush leaves payload untouched; only the state is squashed
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
         end else if (!flush) begin
            case (state_q)
               EMPTY: if (in_xfer) main_q <= in_data;
               ONE: begin
                  if (in_xfer && out_xfer) main_q <= in_data;
                  else if (in_xfer)        skid_q <= in_data;
               end
               FULL:    if (out_xfer) main_q <= skid_q;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised elastic pipeline register that replaces the fixed-width, always-advancing inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined MIPS datapath. It adds a valid/ready handshake, stall back-pressure and synchronous flush for branch squash. An optional skid buffer breaks the combinational ready path between stages. A saturating stall counter supports CPI analysis in simulation.

Parameters:
WIDTH, 64, payload bits carried per beat (IF/ID 64, ID/EX 128, EX/MEM 96, MEM/WB 64 or wider once control fields are bussed)
SKID, 1, 0 = single register with combinational in_ready; 1 = two-entry skid buffer with registered in_ready
RESET_VAL, 0, value loaded into every data register on reset (WIDTH bits, zero-extended)
CNT_W, 16, width of stall_count

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream beat present
in_ready  output  1  stage can accept a beat this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  downstream beat present
out_ready  input  1  downstream accepts this cycle (0 = stall)
out_data  output  WIDTH  downstream payload
flush  input  1  squash all held beats (branch taken / mispredict)
occupancy  output  2  beats held: 0..1 (SKID=0), 0..2 (SKID=1)
stall_count  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset: clk and rst as named; rst asynchronous, active-high. On rst all valid bits = 0, out_valid = 0, occupancy = 0, stall_count = 0, out_data and skid data = RESET_VAL. With SKID=1, in_ready = 1 after reset; with SKID=0, in_ready = 1 while out_valid = 0.
- Transfer rules: input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready. Both take effect on the same rising edge.
- SKID=0:
  - in_ready = ~flush & (out_ready | ~out_valid), combinational.
  - On an input transfer: out_data <= in_data, out_valid <= 1.
  - Else on an output transfer: out_valid <= 0.
  - Latency 1 cycle; throughput 1 beat/cycle.
- SKID=1, states EMPTY (occ 0), ONE (occ 1, main valid), FULL (occ 2, main + skid valid):
  - in_ready = registered (state != FULL) & ~flush. No combinational path from out_ready.
  - EMPTY: input transfer -> main <= in_data, go to ONE.
  - ONE:
    - input and output transfer together -> main <= in_data, stay ONE.
    - input only -> skid <= in_data, go to FULL.
    - output only -> go to EMPTY.
  - FULL: output transfer -> main <= skid, go to ONE. No input is accepted in FULL.
  - out_data always = main register. Latency 1 cycle; sustained 1 beat/cycle with out_ready held high.
- Ordering: beats leave in arrival order; a beat is never dropped or duplicated except by flush.
- Flush:
  - Synchronous, with priority over everything else. In the cycle flush = 1, in_ready = 0, so no upstream beat is lost silently.
  - On the next edge all valid bits clear and the state goes to EMPTY.
  - The output transfer in the flush cycle is still reported to downstream, since out_valid is high in that cycle, but the beat is not retained.
  - Data registers hold their previous contents and are not cleared.
- Data hold: while out_valid = 1 and out_ready = 0, out_data and out_valid are stable (AXI-style; required for MEM-stage SRAM address hold).
- stall_count: increments on every edge where out_valid & ~out_ready, saturates at 2^CNT_W-1, is unaffected by flush, and clears only on rst.
- Reset mid-operation: rst asserted asynchronously at any time clears all state immediately, without waiting for a clock edge. Deassertion is assumed synchronised at the top level.
- Width rule: WIDTH ≥ 1. No internal truncation or extension of payload.

Test Plan:
1. Streaming: SKID=1, WIDTH=64, out_ready=1, drive 0x1..0x10 back-to-back -> out_data shows 0x1..0x10 on consecutive cycles, each 1 cycle after input; occupancy stays 1; stall_count = 0.
2. Back-pressure: SKID=1, send 0xA, 0xB, 0xC with out_ready=0 -> 0xA in main, 0xB in skid, occupancy = 2, in_ready = 0 on the next cycle, 0xC held upstream. Raise out_ready -> outputs 0xA, 0xB, 0xC in order; stall_count = number of stalled cycles.
3. Flush in FULL: occupancy = 2 with out_ready=0, assert flush with in_valid=1 and in_data=0xD -> in_ready = 0 that cycle; next cycle out_valid = 0, occupancy = 0, 0xD not captured.
4. SKID=0 combinational ready: out_valid=1, toggle out_ready -> in_ready follows out_ready in the same cycle. Simultaneous in/out transfer replaces out_data with no bubble.
5. Async reset mid-stall: occupancy = 2, stall_count = 5, pulse rst between clock edges -> out_valid = 0, occupancy = 0, stall_count = 0, out_data = RESET_VAL immediately.
6. Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_count stops at 15.
